// File: rtl/cam_pkg.sv
// Shared constants and FSM encoding for the camera capture path.
package cam_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int FB_W     = 320;
   localparam int FB_H     = 240;
   localparam int ADDR_W   = 17;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FRAME,
      BYTE_HI,
      BYTE_LO
   } cap_state_t;

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchronizer with a history flop for edge detection on bit 0.
module cam_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] q,
   output logic         rise,
   output logic         fall
);

   logic [W-1:0] meta;
   logic         prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= '0;
         q    <= '0;
         prev <= 1'b0;
      end else begin
         meta <= din;
         q    <= meta;
         prev <= q[0];
      end
   end

   assign rise = q[0] & ~prev;
   assign fall = ~q[0] & prev;

endmodule

// File: rtl/camera_capture.sv
// RGB565 camera byte stream to 2:1 decimated RGB444 frame-buffer writes.
module camera_capture #(
   parameter int H_ACTIVE = cam_pkg::H_ACTIVE,
   parameter int V_ACTIVE = cam_pkg::V_ACTIVE,
   parameter int ADDR_W   = cam_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cam_pclk,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [7:0]        cam_d,
   input  logic              capture_en,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [11:0]       fb_data,
   output logic              frame_done,
   output logic              busy,
   output logic              err_line
);

   localparam int XW = $clog2(H_ACTIVE + 2);
   localparam int YW = $clog2(V_ACTIVE + 2);
   localparam logic [XW-1:0]     X_END    = XW'(H_ACTIVE);
   localparam logic [XW-1:0]     X_SAT    = XW'(H_ACTIVE + 1);
   localparam logic [YW-1:0]     Y_END    = YW'(V_ACTIVE);
   localparam logic [YW-1:0]     Y_SAT    = YW'(V_ACTIVE + 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE / 2);

   logic       pclk_s, pclk_rise, pclk_fall;
   logic       vsync_s, vsync_rise, vsync_fall;
   logic       href_s, href_rise, href_fall;
   logic [7:0] d_s;
   logic       d_rise, d_fall;
   logic       unused_ok;

   cam_sync #(.W(1)) u_sync_pclk (
      .clk(clk), .reset_n(reset_n), .din(cam_pclk),
      .q(pclk_s), .rise(pclk_rise), .fall(pclk_fall)
   );
   cam_sync #(.W(1)) u_sync_vsync (
      .clk(clk), .reset_n(reset_n), .din(cam_vsync),
      .q(vsync_s), .rise(vsync_rise), .fall(vsync_fall)
   );
   cam_sync #(.W(1)) u_sync_href (
      .clk(clk), .reset_n(reset_n), .din(cam_href),
      .q(href_s), .rise(href_rise), .fall(href_fall)
   );
   cam_sync #(.W(8)) u_sync_d (
      .clk(clk), .reset_n(reset_n), .din(cam_d),
      .q(d_s), .rise(d_rise), .fall(d_fall)
   );

   assign unused_ok = &{1'b0, pclk_s, pclk_fall, vsync_s, href_rise, d_rise, d_fall};

   cam_pkg::cap_state_t state;
   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] row_base;
   logic [6:0]        hi;
   logic              frame_err;

   logic          in_line, sample, line_end, frame_end, frame_bad;
   logic [YW-1:0] y_line;

   // Line end is resolved before frame end so a coincident vsync rise sees the final y.
   always_comb begin
      in_line   = (state == cam_pkg::BYTE_HI) || (state == cam_pkg::BYTE_LO);
      sample    = pclk_rise & href_s;
      line_end  = href_fall & in_line;
      frame_end = vsync_rise & in_line;
      y_line    = y;
      frame_bad = frame_err;
      if (line_end) begin
         y_line = (y == Y_SAT) ? y : y + YW'(1);
         if (state == cam_pkg::BYTE_LO || x != X_END) frame_bad = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= cam_pkg::IDLE;
         x          <= '0;
         y          <= '0;
         addr       <= '0;
         row_base   <= '0;
         hi         <= '0;
         frame_err  <= 1'b0;
         err_line   <= 1'b0;
         busy       <= 1'b0;
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_data    <= '0;
         frame_done <= 1'b0;
      end else begin
         fb_we      <= 1'b0;
         frame_done <= 1'b0;

         if (line_end) begin
            x         <= '0;
            y         <= y_line;
            frame_err <= frame_bad;
            if (frame_bad) err_line <= 1'b1;
            // Re-seed the address from the row base so malformed lines cannot skew later rows.
            if (y[0]) begin
               row_base <= row_base + ROW_STEP;
               addr     <= row_base + ROW_STEP;
            end else begin
               addr     <= row_base;
            end
         end

         case (state)
            cam_pkg::IDLE: begin
               if (capture_en) begin
                  state    <= cam_pkg::WAIT_FRAME;
                  busy     <= 1'b1;
                  err_line <= 1'b0;
               end
            end
            cam_pkg::WAIT_FRAME: begin
               if (!capture_en) begin
                  state <= cam_pkg::IDLE;
                  busy  <= 1'b0;
               end else if (vsync_fall) begin
                  x         <= '0;
                  y         <= '0;
                  addr      <= '0;
                  row_base  <= '0;
                  frame_err <= 1'b0;
                  state     <= cam_pkg::BYTE_HI;
               end
            end
            cam_pkg::BYTE_HI, cam_pkg::BYTE_LO: begin
               if (frame_end) begin
                  if (y_line == Y_END && !frame_bad) frame_done <= 1'b1;
                  else                               err_line   <= 1'b1;
                  state <= capture_en ? cam_pkg::WAIT_FRAME : cam_pkg::IDLE;
                  busy  <= capture_en;
               end else if (line_end) begin
                  state <= cam_pkg::BYTE_HI;
               end else if (sample) begin
                  if (state == cam_pkg::BYTE_HI) begin
                     hi    <= {d_s[7:4], d_s[2:0]};
                     state <= cam_pkg::BYTE_LO;
                  end else begin
                     state <= cam_pkg::BYTE_HI;
                     x     <= (x == X_SAT) ? x : x + XW'(1);
                     if (x < X_END && y < Y_END && !x[0] && !y[0]) begin
                        fb_we   <= 1'b1;
                        fb_addr <= addr;
                        fb_data <= {hi[6:3], hi[2:0], d_s[7], d_s[4:1]};
                        addr    <= addr + ADDR_W'(1);
                     end
                  end
               end
            end
            default: begin
               state <= cam_pkg::IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_camera_capture.sv
// Random camera streams checked against a frame-level model of the expected frame-buffer writes.
module tb_camera_capture;

   localparam int H  = 16;
   localparam int V  = 12;
   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cam_pclk, cam_vsync, cam_href;
   logic [7:0]    cam_d;
   logic          capture_en;
   logic          fb_we;
   logic [AW-1:0] fb_addr;
   logic [11:0]   fb_data;
   logic          frame_done, busy, err_line;

   camera_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
      .clk(clk), .reset_n(reset_n), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
      .cam_href(cam_href), .cam_d(cam_d), .capture_en(capture_en),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
      .frame_done(frame_done), .busy(busy), .err_line(err_line)
   );

   always #10 clk = ~clk;

   typedef struct {
      int addr;
      int data;
      int due;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   checks = 0, errors = 0, cyc = 0;
   int   fd_count = 0, wr_total = 0, last_addr = -1;
   bit   capturing = 1'b0;
   logic fd_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, expv, expv, cyc);
      end
   endfunction

   // RGB565 -> RGB444 by dropping low-order colour bits.
   function automatic int rgb444(input logic [7:0] hi, input logic [7:0] lo);
      int r5, g6, b5;
      r5 = int'(hi) / 8;
      g6 = (int'(hi) % 8) * 8 + int'(lo) / 32;
      b5 = int'(lo) % 32;
      return (r5 / 2) * 256 + (g6 / 4) * 16 + (b5 / 2);
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (fb_we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_we", int'(fb_we), 0);
            end else begin
               cur = exp_q.pop_front();
               check("fb_addr", int'(fb_addr), cur.addr);
               check("fb_data", int'(fb_data), cur.data);
               check("we_cycle", cyc, cur.due);
               wr_total++;
               last_addr = int'(fb_addr);
            end
         end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
            check("missed_we", int'(fb_we), 1);
            void'(exp_q.pop_front());
         end
         if (frame_done) begin
            fd_count++;
            check("frame_done_width", int'(fd_prev), 0);
         end
         fd_prev = frame_done;
      end
   end

   // One camera byte: pclk low for 2 clk with data changing, then high for 2 clk.
   task automatic pclk_byte(input logic h, input logic [7:0] b, input logic v, output int rise_cyc);
      @(negedge clk);
      cam_pclk  = 1'b0;
      cam_href  = h;
      cam_d     = b;
      cam_vsync = v;
      @(negedge clk);
      @(negedge clk);
      cam_pclk = 1'b1;
      rise_cyc = cyc;
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_fb_we"},      int'(fb_we),      0);
      check({tag, "_fb_addr"},    int'(fb_addr),    0);
      check({tag, "_fb_data"},    int'(fb_data),    0);
      check({tag, "_frame_done"}, int'(frame_done), 0);
      check({tag, "_busy"},       int'(busy),       0);
      check({tag, "_err_line"},   int'(err_line),   0);
   endtask

   task automatic send_line(input int y, input int npix, input bit odd, input bit vs_end, input bit lit);
      int         rc;
      logic [7:0] hi, lo;
      exp_t       e;
      for (int x = 0; x < npix; x++) begin
         hi = 8'($urandom);
         lo = 8'($urandom);
         if (lit && y == 0 && x == 0) begin hi = 8'hF8; lo = 8'h1F; end
         if (lit && y == 0 && x == 2) begin hi = 8'h07; lo = 8'hE0; end
         pclk_byte(1'b1, hi, 1'b0, rc);
         pclk_byte(1'b1, lo, 1'b0, rc);
         if (capturing && x < H && y < V && x % 2 == 0 && y % 2 == 0) begin
            e.addr = (y / 2) * (H / 2) + x / 2;
            if (lit && y == 0 && x == 0)      e.data = 'hF0F;
            else if (lit && y == 0 && x == 2) e.data = 'h0F0;
            else                              e.data = rgb444(hi, lo);
            e.due = rc + 3;
            exp_q.push_back(e);
         end
      end
      if (odd) pclk_byte(1'b1, 8'($urandom), 1'b0, rc);
      repeat (2 + $urandom_range(0, 2)) pclk_byte(1'b0, 8'h00, vs_end, rc);
   endtask

   task automatic send_frame(input int nlines, input int long_y, input int odd_y,
                             input int drop_y, input int rst_y, input bit vs_same, input bit lit);
      int rc;
      repeat (2 + $urandom_range(0, 2)) pclk_byte(1'b0, 8'h00, 1'b1, rc);
      capturing = capture_en;
      repeat (3) pclk_byte(1'b0, 8'h00, 1'b0, rc);
      for (int y = 0; y < nlines; y++) begin
         if (y == rst_y) begin
            @(negedge clk);
            reset_n = 1'b0;
            #1;
            check_reset_outputs("midreset");
            check("pending_at_reset", exp_q.size(), 0);
            @(negedge clk);
            reset_n   = 1'b1;
            capturing = 1'b0;
            break;
         end
         if (y == drop_y) capture_en = 1'b0;
         send_line(y, (y == long_y) ? H + 2 : H, y == odd_y, vs_same && (y == nlines - 1), lit);
      end
      repeat (3) pclk_byte(1'b0, 8'h00, 1'b1, rc);
   endtask

   int wr0;

   initial begin
      reset_n    = 1'b0;
      cam_pclk   = 1'b0;
      cam_vsync  = 1'b1;
      cam_href   = 1'b0;
      cam_d      = 8'h00;
      capture_en = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_busy", int'(busy), 0);
      capture_en = 1'b1;
      repeat (2) @(negedge clk);
      check("armed_busy", int'(busy), 1);

      // Good frame, literal colours, last href fall coincides with vsync rise.
      wr0 = wr_total;
      send_frame(V, -1, -1, -1, -1, 1'b1, 1'b1);
      check("A_frame_done", fd_count, 1);
      check("A_err_line", int'(err_line), 0);
      check("A_writes", wr_total - wr0, 48);
      check("A_last_addr", last_addr, 47);
      check("A_busy", int'(busy), 1);

      // Over-long even line and an odd-byte line; capture dropped on the last line.
      send_frame(V, 2, 4, V - 1, -1, 1'b0, 1'b0);
      check("B_frame_done", fd_count, 1);
      check("B_err_line", int'(err_line), 1);
      check("B_busy", int'(busy), 0);
      capture_en = 1'b1;
      repeat (3) @(negedge clk);
      check("B_err_cleared", int'(err_line), 0);
      check("B_busy_rearm", int'(busy), 1);

      // Frame ends after only 7 lines.
      send_frame(7, -1, -1, 6, -1, 1'b0, 1'b0);
      check("C_frame_done", fd_count, 1);
      check("C_err_line", int'(err_line), 1);
      check("C_busy", int'(busy), 0);
      capture_en = 1'b1;
      repeat (3) @(negedge clk);
      check("C_err_cleared", int'(err_line), 0);

      // Reset pulsed mid-frame, then a clean frame restarting at address 0.
      send_frame(V, -1, -1, -1, 5, 1'b0, 1'b0);
      check("D_frame_done", fd_count, 1);
      check("D_busy", int'(busy), 1);
      wr0 = wr_total;
      send_frame(V, -1, -1, -1, -1, 1'b0, 1'b0);
      check("E_frame_done", fd_count, 2);
      check("E_writes", wr_total - wr0, 48);
      check("E_last_addr", last_addr, 47);
      check("E_err_line", int'(err_line), 0);

      // capture_en dropped mid-frame: frame completes, then nothing further.
      send_frame(V, -1, -1, 6, -1, 1'b0, 1'b0);
      check("F_frame_done", fd_count, 3);
      check("F_busy", int'(busy), 0);
      wr0 = wr_total;
      send_frame(V, -1, -1, -1, -1, 1'b0, 1'b0);
      check("G_writes", wr_total - wr0, 0);
      check("G_frame_done", fd_count, 3);
      check("G_busy", int'(busy), 0);

      repeat (8) @(negedge clk);
      check("pending_at_end", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
